// File: rtl/dither_pipeline.sv
// dither_pipeline
//   Two-stage colour dithering stage for the VGA path. Each channel is reduced
//   from IN_W to OUT_W significant bits (MSB-aligned, low bits zero) using one
//   of four run-time modes: bypass, ordered Bayer, pseudo-random (LFSR) or
//   1-D error diffusion. Pixel position is tracked from the sof/sol markers.
//
// Ports
//   clk          pixel clock, rising edge
//   rst          synchronous reset, active low
//   mode         0 bypass, 1 ordered, 2 random, 3 error diffusion (latched on sof)
//   in_valid     pixel and markers valid this cycle
//   in_sof       first pixel of frame (implies sol)
//   in_sol       first pixel of line
//   in_visible   pixel is in the active area
//   data_in      packed pixel, channel 0 at the LSBs
//   out_valid    in_valid delayed by two cycles
//   out_visible  in_visible delayed by two cycles
//   data_out     processed pixel
module dither_pipeline #(
    parameter int CHANNELS = 3,
    parameter int IN_W     = 8,
    parameter int OUT_W    = 4,
    parameter int BAYER_N  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               mode,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic                     in_sol,
    input  logic                     in_visible,
    input  logic [CHANNELS*IN_W-1:0] data_in,
    output logic                     out_valid,
    output logic                     out_visible,
    output logic [CHANNELS*IN_W-1:0] data_out
);

    localparam int DROP  = IN_W - OUT_W;
    localparam int LB    = $clog2(BAYER_N);
    localparam int SHIFT = DROP - 2 * LB;
    localparam int PW    = CHANNELS * IN_W;
    localparam int TW    = CHANNELS * DROP;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    localparam logic [3:0] BAYER4 [16] = '{
        4'd0,  4'd8,  4'd2,  4'd10,
        4'd12, 4'd4,  4'd14, 4'd6,
        4'd3,  4'd11, 4'd1,  4'd9,
        4'd15, 4'd7,  4'd13, 4'd5
    };
    localparam logic [1:0] BAYER2 [4] = '{2'd0, 2'd2, 2'd3, 2'd1};

    // Frame-level state
    logic [1:0]    mode_q, mode_d;
    logic [LB-1:0] x_q, x_d;
    logic [LB-1:0] y_q, y_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [TW-1:0] e_q, e_d;

    // Stage 1
    logic          s1_valid_q, s1_valid_d;
    logic          s1_visible_q, s1_visible_d;
    logic          s1_first_q, s1_first_d;
    logic [1:0]    s1_mode_q, s1_mode_d;
    logic [PW-1:0] s1_data_q, s1_data_d;
    logic [TW-1:0] s1_thr_q, s1_thr_d;

    // Stage 2
    logic          out_valid_q, out_valid_d;
    logic          out_visible_q, out_visible_d;
    logic [PW-1:0] data_out_q, data_out_d;

    // Stage-1 combinational signals
    logic [1:0]      mode_eff;
    logic [LB-1:0]   x_pix, y_pix;
    logic [15:0]     lfsr_pix;
    logic            lfsr_fb;
    logic [3:0]      bayer_val;
    logic [DROP-1:0] t_ord;
    logic [TW-1:0]   thr;

    // Markers of the current pixel are applied before it picks its position,
    // mode and LFSR word, so the sof pixel itself already uses the new frame.
    always_comb begin
        mode_eff = in_sof ? mode : mode_q;
        x_pix    = (in_sof || in_sol) ? '0 : x_q + LB'(1);
        y_pix    = in_sof ? '0 : (in_sol ? y_q + LB'(1) : y_q);
        lfsr_pix = in_sof ? LFSR_SEED : lfsr_q;
        lfsr_fb  = lfsr_pix[0] ^ lfsr_pix[2] ^ lfsr_pix[3] ^ lfsr_pix[5];

        bayer_val = '0;
        if (BAYER_N == 4) begin
            bayer_val = BAYER4[4'({y_pix, x_pix})];
        end else begin
            bayer_val = {2'b00, BAYER2[2'({y_pix, x_pix})]};
        end
        t_ord = DROP'(bayer_val) << SHIFT;

        // Error diffusion leaves thr at zero: its threshold is the live
        // residue, picked up in stage 2 so the feedback closes in one cycle.
        thr = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int b = 0; b < DROP; b++) begin
                if (mode_eff == 2'd1) begin
                    thr[c*DROP+b] = t_ord[b];
                end else if (mode_eff == 2'd2) begin
                    thr[c*DROP+b] = lfsr_pix[(c*DROP+b) % 16];
                end
            end
        end
    end

    always_comb begin
        mode_d       = mode_q;
        x_d          = x_q;
        y_d          = y_q;
        lfsr_d       = lfsr_q;
        s1_valid_d   = in_valid;
        s1_visible_d = s1_visible_q;
        s1_first_d   = s1_first_q;
        s1_mode_d    = s1_mode_q;
        s1_data_d    = s1_data_q;
        s1_thr_d     = s1_thr_q;
        if (in_valid) begin
            mode_d       = mode_eff;
            x_d          = x_pix;
            y_d          = y_pix;
            lfsr_d       = {lfsr_fb, lfsr_pix[15:1]};
            s1_visible_d = in_visible;
            s1_first_d   = in_sof | in_sol;
            s1_mode_d    = mode_eff;
            s1_data_d    = data_in;
            s1_thr_d     = thr;
        end
    end

    // Stage-2 combinational signals
    logic [IN_W:0]    sum;
    logic [OUT_W-1:0] q;
    logic [DROP-1:0]  t;
    logic [DROP-1:0]  res;
    logic [PW-1:0]    dith;
    logic [TW-1:0]    res_all;

    always_comb begin
        sum     = '0;
        q       = '0;
        t       = '0;
        res     = '0;
        dith    = '0;
        res_all = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            // A line-start pixel sees a cleared residue.
            if (s1_mode_q == 2'd3) begin
                t = s1_first_q ? '0 : e_q[c*DROP +: DROP];
            end else begin
                t = s1_thr_q[c*DROP +: DROP];
            end
            sum = {1'b0, s1_data_q[c*IN_W +: IN_W]} + {{(IN_W+1-DROP){1'b0}}, t};
            if (sum[IN_W]) begin
                q   = '1;
                res = '0;
            end else begin
                q   = sum[IN_W-1:DROP];
                res = sum[DROP-1:0];
            end
            dith[c*IN_W +: IN_W]    = {q, {DROP{1'b0}}};
            res_all[c*DROP +: DROP] = res;
        end
    end

    always_comb begin
        out_valid_d   = s1_valid_q;
        out_visible_d = out_visible_q;
        data_out_d    = data_out_q;
        e_d           = e_q;
        if (s1_valid_q) begin
            out_visible_d = s1_visible_q;
            if (s1_mode_q == 2'd0) begin
                data_out_d = s1_data_q;
            end else if (!s1_visible_q) begin
                data_out_d = '0;
            end else begin
                data_out_d = dith;
            end
            // Blanked pixels keep the residue, except that a line start
            // always clears it.
            if (s1_mode_q == 2'd3 && s1_visible_q) begin
                e_d = res_all;
            end else if (s1_first_q) begin
                e_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q        <= '0;
            x_q           <= '0;
            y_q           <= '0;
            lfsr_q        <= LFSR_SEED;
            e_q           <= '0;
            s1_valid_q    <= 1'b0;
            s1_visible_q  <= 1'b0;
            s1_first_q    <= 1'b0;
            s1_mode_q     <= '0;
            s1_data_q     <= '0;
            s1_thr_q      <= '0;
            out_valid_q   <= 1'b0;
            out_visible_q <= 1'b0;
            data_out_q    <= '0;
        end else begin
            mode_q        <= mode_d;
            x_q           <= x_d;
            y_q           <= y_d;
            lfsr_q        <= lfsr_d;
            e_q           <= e_d;
            s1_valid_q    <= s1_valid_d;
            s1_visible_q  <= s1_visible_d;
            s1_first_q    <= s1_first_d;
            s1_mode_q     <= s1_mode_d;
            s1_data_q     <= s1_data_d;
            s1_thr_q      <= s1_thr_d;
            out_valid_q   <= out_valid_d;
            out_visible_q <= out_visible_d;
            data_out_q    <= data_out_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_visible = out_visible_q;
    assign data_out    = data_out_q;

endmodule

// File: tb/tb_dither_pipeline.sv
module tb_dither_pipeline;

    logic        clk;
    logic        rst;
    logic [1:0]  mode;
    logic        in_valid;
    logic        in_sof;
    logic        in_sol;
    logic        in_visible;
    logic [23:0] data_in;
    logic        out_valid;
    logic        out_visible;
    logic [23:0] data_out;

    int n_checks = 0;
    int n_fail   = 0;

    dither_pipeline #(
        .CHANNELS(3), .IN_W(8), .OUT_W(4), .BAYER_N(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_sol     (in_sol),
        .in_visible (in_visible),
        .data_in    (data_in),
        .out_valid  (out_valid),
        .out_visible(out_visible),
        .data_out   (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of input, then return 1 time unit after the edge.
    task automatic drive(input logic v, input logic sof, input logic sol,
                         input logic vis, input logic [23:0] d);
        in_valid   = v;
        in_sof     = sof;
        in_sol     = sol;
        in_visible = vis;
        data_in    = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        logic b;
        b = l[0] ^ l[2] ^ l[3] ^ l[5];
        return {b, l[15:1]};
    endfunction

    function automatic logic [23:0] rnd_exp(input logic [23:0] d, input logic [15:0] l,
                                            input logic vis);
        logic [23:0] r;
        logic [8:0]  s;
        r = '0;
        if (vis) begin
            for (int c = 0; c < 3; c++) begin
                s = {1'b0, d[c*8 +: 8]} + {5'b0, l[c*4 +: 4]};
                r[c*8 +: 8] = s[8] ? 8'hF0 : {s[7:4], 4'h0};
            end
        end
        return r;
    endfunction

    task automatic test_reset();
        rst  = 1'b0;
        mode = 2'd1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, i == 0, 1'b0, 1'b1, 24'hABCDEF);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_valid[%0d]: got %b expected 0", i, out_valid);
            end
            n_checks++;
            if (data_out !== 24'h0) begin
                n_fail++;
                $display("FAIL rst_data[%0d]: got %h expected 000000", i, data_out);
            end
        end
        rst = 1'b1;
        // No sof yet, so mode stays bypass even though mode=1 is presented.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 24'h123456);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_lat1: got %b expected 0", out_valid);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        n_checks++;
        if (out_valid !== 1'b1 || data_out !== 24'h123456) begin
            n_fail++;
            $display("FAIL rst_bypass: got v=%b %h expected v=1 123456", out_valid, data_out);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_drain: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_mode_latch_blank();
        mode = 2'd1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 24'h0A0B0C);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        n_checks++;
        if (out_valid !== 1'b1 || out_visible !== 1'b0 || data_out !== 24'h0A0B0C) begin
            n_fail++;
            $display("FAIL latch_bypass: got v=%b vis=%b %h expected v=1 vis=0 0a0b0c",
                     out_valid, out_visible, data_out);
        end
        // sof latches ordered mode; blanked pixel then x=1 (B=8).
        drive(1'b1, 1'b1, 1'b0, 1'b0, 24'h777777);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 24'h777777);
        n_checks++;
        if (out_valid !== 1'b1 || out_visible !== 1'b0 || data_out !== 24'h0) begin
            n_fail++;
            $display("FAIL blank: got v=%b vis=%b %h expected v=1 vis=0 000000",
                     out_valid, out_visible, data_out);
        end
        mode = 2'd0;
        // x=2 (B=2); mode change without sof must not take effect.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 24'h777777);
        n_checks++;
        if (out_valid !== 1'b1 || out_visible !== 1'b1 || data_out !== 24'h707070) begin
            n_fail++;
            $display("FAIL ord_after_blank: got v=%b vis=%b %h expected v=1 vis=1 707070",
                     out_valid, out_visible, data_out);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        n_checks++;
        if (data_out !== 24'h707070) begin
            n_fail++;
            $display("FAIL latch_hold: got %h expected 707070", data_out);
        end
    endtask

    task automatic test_ordered();
        logic [7:0] exp_tbl [16];
        int cnt70;
        exp_tbl = '{8'h70, 8'h70, 8'h70, 8'h80,
                    8'h80, 8'h70, 8'h80, 8'h70,
                    8'h70, 8'h80, 8'h70, 8'h80,
                    8'h80, 8'h70, 8'h80, 8'h70};
        cnt70 = 0;
        mode  = 2'd1;
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) drive(1'b1, i == 0, (i % 4 == 0) && (i != 0), 1'b1, 24'h777777);
            else        drive(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
            if (i > 0) begin
                n_checks++;
                if (out_valid !== 1'b1 || data_out !== {3{exp_tbl[i-1]}}) begin
                    n_fail++;
                    $display("FAIL ordered[%0d]: got v=%b %h expected v=1 %h",
                             i - 1, out_valid, data_out, {3{exp_tbl[i-1]}});
                end
                if (data_out[7:0] == 8'h70) cnt70++;
            end
        end
        n_checks++;
        if (cnt70 != 9) begin
            n_fail++;
            $display("FAIL ordered_count: got %0d expected 9", cnt70);
        end
    endtask

    task automatic test_saturation();
        mode = 2'd1;
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) drive(1'b1, i == 0, (i % 4 == 0) && (i != 0), 1'b1, 24'hFFFFFF);
            else        drive(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
            if (i > 0) begin
                n_checks++;
                if (data_out !== 24'hF0F0F0) begin
                    n_fail++;
                    $display("FAIL sat_ord[%0d]: got %h expected f0f0f0", i - 1, data_out);
                end
            end
        end
        mode = 2'd3;
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) drive(1'b1, i == 0, 1'b0, 1'b1, 24'hF9F9F9);
            else       drive(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
            if (i > 0) begin
                n_checks++;
                if (data_out !== 24'hF0F0F0) begin
                    n_fail++;
                    $display("FAIL sat_ed[%0d]: got %h expected f0f0f0", i - 1, data_out);
                end
            end
        end
    endtask

    task automatic test_error_diffusion();
        logic        sof_t [7];
        logic        sol_t [7];
        logic        vis_t [7];
        logic [23:0] exp_t [7];
        sof_t = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        sol_t = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vis_t = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        exp_t = '{24'h000000, 24'h101010, 24'h000000, 24'h000000,
                  24'h000000, 24'h101010, 24'h000000};
        mode = 2'd3;
        for (int i = 0; i <= 7; i++) begin
            if (i < 7) drive(1'b1, sof_t[i], sol_t[i], vis_t[i], 24'h080808);
            else       drive(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
            if (i > 0) begin
                n_checks++;
                if (out_valid !== 1'b1 || data_out !== exp_t[i-1]) begin
                    n_fail++;
                    $display("FAIL ed[%0d]: got v=%b %h expected v=1 %h",
                             i - 1, out_valid, data_out, exp_t[i-1]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] l;
        logic [23:0] d;
        logic [23:0] cur_exp, prev_exp;
        logic        vis, cur_v, prev_v;
        int          n;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        rst      = 1'b1;
        mode     = 2'd2;
        l        = 16'hACE1;
        n        = 0;
        prev_v   = 1'b0;
        prev_exp = '0;
        while (n < 1024) begin
            if (n > 0 && $urandom_range(3) == 0) begin
                drive(1'b0, 1'b0, 1'b0, 1'b0, 24'($urandom));
                cur_v   = 1'b0;
                cur_exp = '0;
            end else begin
                d   = (n == 0) ? 24'h080808 : 24'($urandom);
                vis = (n == 0) ? 1'b1 : ($urandom_range(7) != 0);
                drive(1'b1, n == 0, 1'b0, vis, d);
                cur_exp = (n == 0) ? 24'h101000 : rnd_exp(d, l, vis);
                l       = lfsr_next(l);
                cur_v   = 1'b1;
                n++;
            end
            n_checks++;
            if (out_valid !== prev_v) begin
                n_fail++;
                $display("FAIL rnd_valid[%0d]: got %b expected %b", n, out_valid, prev_v);
            end
            if (prev_v) begin
                n_checks++;
                if (data_out !== prev_exp) begin
                    n_fail++;
                    $display("FAIL rnd_data[%0d]: got %h expected %h", n, data_out, prev_exp);
                end
            end
            prev_v   = cur_v;
            prev_exp = cur_exp;
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        n_checks++;
        if (out_valid !== 1'b1 || data_out !== prev_exp) begin
            n_fail++;
            $display("FAIL rnd_last: got v=%b %h expected v=1 %h", out_valid, data_out, prev_exp);
        end
    endtask

    initial begin
        rst        = 1'b0;
        mode       = 2'd0;
        in_valid   = 1'b0;
        in_sof     = 1'b0;
        in_sol     = 1'b0;
        in_visible = 1'b0;
        data_in    = '0;
        test_reset();
        test_mode_latch_blank();
        test_ordered();
        test_saturation();
        test_error_diffusion();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
